tx_segment_sequencer: RTL

Packet-payload address sequencer on the Ethernet TX clock. It drives the read side of the VRAM/segment-buffer memory controller that sits directly downstream. Per granted frame slot it walks one segment of SEGMENT_BYTES bytes, with R,G,B bytes interleaved per pixel, and tags the frame with txid/segment_num. The first copy of each segment (txid=1) reads VRAM and fills the segment buffer. Copies 2..redundancy replay from the buffer. The segment advances after the last redundant copy.

---
 rtl/tx_segment_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tx_segment_sequencer.sv
// Segment address sequencer on the Ethernet TX clock: walks one RGB-interleaved
// segment per granted frame slot and tags it with the copy index and segment number.
module tx_segment_sequencer #(
  parameter int SEGMENT_BYTES      = 1080,
  parameter int SEGMENT_NUMBER_MAX = 500,
  parameter int PIXELS_PER_FRAME   = 2073600,
  parameter int FINISH_CYCLES      = 3
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  redundancy,
  input  logic [23:0] startaddr,
  output logic        busy,
  output logic [7:0]  txid,
  output logic [15:0] segment_num,
  output logic [23:0] vramaddr,
  output logic [2:0]  vramaddr_c,
  output logic [12:0] count_for_bram,
  output logic [12:0] count_for_bram_b,
  output logic        count_for_bram_en,
  output logic        data_user,
  output logic [23:0] lastaddr,
  output logic        frame_done,
  output logic        segment_wrap
);

  localparam int FW = (FINISH_CYCLES > 1) ? $clog2(FINISH_CYCLES + 1) : 1;
  localparam logic [12:0]   LAST_B   = 13'(SEGMENT_BYTES - 1);
  localparam logic [23:0]   PIX_LAST = 24'(PIXELS_PER_FRAME - 1);
  localparam logic [15:0]   SEG_LAST = 16'(SEGMENT_NUMBER_MAX - 1);
  localparam logic [FW-1:0] FIN_LAST = FW'(FINISH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PAYLOAD, FINISH} state_t;

  state_t        state, state_d;
  logic [FW-1:0] fin_cnt, fin_cnt_d;
  logic [12:0]   b;
  logic [7:0]    red_l, red_in, txid_load;
  logic [23:0]   vram_inc, vram_step;
  logic          last_byte, last_fin, seg_done, fin_pulse, wrap_d;

  assign busy             = (state != IDLE);
  assign count_for_bram   = b;
  assign count_for_bram_b = b;

  // Datapath helpers; a redundancy of 0 means a single copy.
  always_comb begin
    red_in    = (redundancy == 8'd0) ? 8'd1 : redundancy;
    txid_load = (txid > red_in) ? 8'd1 : txid;
    vram_inc  = (vramaddr == PIX_LAST) ? 24'd0 : vramaddr + 24'd1;
    vram_step = (vramaddr_c == 3'd2) ? vram_inc : vramaddr;
    last_byte = (b == LAST_B);
    last_fin  = (fin_cnt == FIN_LAST);
    seg_done  = (txid == red_l);
  end

  always_comb begin
    state_d   = state;
    fin_cnt_d = '0;
    case (state)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = PAYLOAD;
      PAYLOAD: if (last_byte) state_d = FINISH;
      FINISH: begin
        if (last_fin) state_d = IDLE;
        else fin_cnt_d = fin_cnt + FW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Pulses are registered so they line up with the final FINISH cycle.
    fin_pulse = (state_d == FINISH) && (fin_cnt_d == FIN_LAST);
    wrap_d    = fin_pulse && seg_done && (segment_num == SEG_LAST);
  end

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state             <= IDLE;
      fin_cnt           <= '0;
      red_l             <= 8'd1;
      txid              <= 8'd1;
      segment_num       <= '0;
      vramaddr          <= '0;
      vramaddr_c        <= '0;
      b                 <= '0;
      count_for_bram_en <= 1'b0;
      data_user         <= 1'b0;
      lastaddr          <= '0;
      frame_done        <= 1'b0;
      segment_wrap      <= 1'b0;
    end else begin
      state             <= state_d;
      fin_cnt           <= fin_cnt_d;
      data_user         <= (state_d == PAYLOAD);
      frame_done        <= fin_pulse;
      segment_wrap      <= wrap_d;
      count_for_bram_en <= 1'b0;
      case (state)
        LOAD: begin
          red_l             <= red_in;
          txid              <= txid_load;
          vramaddr          <= startaddr;
          vramaddr_c        <= 3'd0;
          b                 <= 13'd0;
          count_for_bram_en <= (txid_load == 8'd1);
        end
        PAYLOAD: begin
          if (!last_byte) begin
            b                 <= b + 13'd1;
            vramaddr_c        <= (vramaddr_c == 3'd2) ? 3'd0 : vramaddr_c + 3'd1;
            vramaddr          <= vram_step;
            count_for_bram_en <= (txid == 8'd1);
          end else if (txid == 8'd1) begin
            // Only the buffer-filling copy records where the segment ended.
            lastaddr <= vram_step;
          end
        end
        FINISH: begin
          if (last_fin) begin
            if (seg_done) begin
              txid        <= 8'd1;
              segment_num <= (segment_num == SEG_LAST) ? 16'd0 : segment_num + 16'd1;
            end else begin
              txid <= txid + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
